pipelined_adder: RTL and testbench

//   Parametrised successor to fulladder: WIDTH-bit adder, carry chain split into STAGES

---
 rtl/pipelined_adder.sv | 138 +++++++++++++
 tb/tb_pipelined_adder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder whose carry chain is cut into STAGES registered
// chunks of CHUNK = WIDTH/STAGES bits. Valid/ready on both sides, one result per
// cycle, fixed latency of STAGES cycles, order preserved.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   in_valid   in   1      a/b/y (and sub) valid this cycle
//   in_ready   out  1      combinational: pipeline advances this cycle
//   a, b       in   WIDTH  operands
//   y          in   1      carry-in
//   sub        in   1      only with ADDSUB_EN: 1 -> a + ~b + 1 (y ignored)
//   out_valid  out  1      s/c valid
//   out_ready  in   1      downstream takes s/c this cycle
//   s          out  WIDTH  sum, registered
//   c          out  1      carry-out, registered
//
// Optional feature macro: ADDSUB_EN (adds the sub port).

module pipelined_adder #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             y,
`ifdef ADDSUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c
);

   localparam int unsigned CHUNK = WIDTH / STAGES;

   if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
      $error("pipelined_adder: need WIDTH>=1, 1<=STAGES<=WIDTH, WIDTH%%STAGES==0");
   end

   // Whole pipeline advances together unless the output is held by downstream.
   logic en_c;
   assign en_c     = !out_valid || out_ready;
   assign in_ready = en_c;

   // Subtraction is folded into the operand at entry: invert b and force carry-in.
   logic [WIDTH-1:0] b_eff_c;
   logic             cin_c;
   always_comb begin
      b_eff_c = b;
      cin_c   = y;
`ifdef ADDSUB_EN
      if (sub) begin
         b_eff_c = ~b;
         cin_c   = 1'b1;
      end
`endif
   end

   // Stage valid bits: bit k belongs to stage k.
   logic [STAGES-1:0] valid_d, valid_q;
   assign valid_d = (valid_q << 1) | STAGES'(in_valid);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) valid_q <= '0;
      else if (en_c) valid_q <= valid_d;
   end

   // Stage k adds chunk k. It keeps the finished low sum bits (deskew) and the
   // not-yet-added high operand bits (skew) moving alongside.
   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int unsigned DONE = (k + 1) * CHUNK;
      localparam int unsigned REM  = WIDTH - DONE;

      logic [CHUNK-1:0] a_in, b_in;
      logic             c_in;
      logic [CHUNK:0]   part;
      logic [DONE-1:0]  sum_d, sum_q;
      logic             carry_q;

      assign part = {1'b0, a_in} + {1'b0, b_in} + {{CHUNK{1'b0}}, c_in};

      if (k == 0) begin : g_head
         assign a_in  = a[CHUNK-1:0];
         assign b_in  = b_eff_c[CHUNK-1:0];
         assign c_in  = cin_c;
         assign sum_d = part[CHUNK-1:0];
      end else begin : g_body
         assign a_in  = g_stg[k-1].g_ops.opa_q[CHUNK-1:0];
         assign b_in  = g_stg[k-1].g_ops.opb_q[CHUNK-1:0];
         assign c_in  = g_stg[k-1].carry_q;
         assign sum_d = {part[CHUNK-1:0], g_stg[k-1].sum_q};
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
         end else if (en_c) begin
            sum_q   <= sum_d;
            carry_q <= part[CHUNK];
         end
      end

      // Operand bits still waiting for later stages; absent in the last stage.
      if (REM > 0) begin : g_ops
         logic [REM-1:0] opa_d, opb_d, opa_q, opb_q;

         if (k == 0) begin : g_src_in
            assign opa_d = a[WIDTH-1:CHUNK];
            assign opb_d = b_eff_c[WIDTH-1:CHUNK];
         end else begin : g_src_prev
            assign opa_d = g_stg[k-1].g_ops.opa_q[REM+CHUNK-1:CHUNK];
            assign opb_d = g_stg[k-1].g_ops.opb_q[REM+CHUNK-1:CHUNK];
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               opa_q <= '0;
               opb_q <= '0;
            end else if (en_c) begin
               opa_q <= opa_d;
               opb_q <= opb_d;
            end
         end
      end
   end

   assign out_valid = valid_q[STAGES-1];
   assign s         = g_stg[STAGES-1].sum_q;
   assign c         = g_stg[STAGES-1].carry_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: an 8-bit/2-stage instance driven with directed
// vectors and a 4-bit/4-stage instance driven exhaustively. A scoreboard of
// expected {c,s} values (plain arithmetic) is checked every output cycle.

module tb_pipelined_adder;

   logic       clk = 1'b0;
   logic       rst;

   logic       iv8, ir8, y8, sub8, ov8, or8, c8;
   logic [7:0] a8, b8, s8;

   logic       iv4, ir4, y4, sub4, ov4, or4, c4;
   logic [3:0] a4, b4, s4;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n_out4 = 0;

   typedef struct { logic [8:0] r; int cyc; } e8_t;
   typedef struct { logic [4:0] r; int cyc; } e4_t;
   e8_t q8[$];
   e4_t q4[$];

   logic [7:0] t2_a [3] = '{8'h01, 8'h80, 8'h7F};
   logic [7:0] t2_b [3] = '{8'h02, 8'h80, 8'h00};
   logic       t2_y [3] = '{1'b0, 1'b1, 1'b1};
   logic [7:0] t2_s [3] = '{8'h03, 8'h01, 8'h80};
   logic       t2_c [3] = '{1'b0, 1'b1, 1'b0};

   logic [7:0] snap_s;
   logic       snap_c;

   always #5 clk = ~clk;

   pipelined_adder #(.WIDTH(8), .STAGES(2)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
      .a(a8), .b(b8), .y(y8),
`ifdef ADDSUB_EN
      .sub(sub8),
`endif
      .out_valid(ov8), .out_ready(or8), .s(s8), .c(c8)
   );

   pipelined_adder #(.WIDTH(4), .STAGES(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
      .a(a4), .b(b4), .y(y4),
`ifdef ADDSUB_EN
      .sub(sub4),
`endif
      .out_valid(ov4), .out_ready(or4), .s(s4), .c(c4)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [8:0] model8(input logic [7:0] av, input logic [7:0] bv,
                                         input logic yv, input logic sv);
      if (sv) return {1'b0, av} + {1'b0, ~bv} + 9'd1;
      return {1'b0, av} + {1'b0, bv} + {8'd0, yv};
   endfunction

   function automatic logic [4:0] model4(input logic [3:0] av, input logic [3:0] bv,
                                         input logic yv);
      return {1'b0, av} + {1'b0, bv} + {4'd0, yv};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // In-flight operations are discarded by reset.
   always @(posedge rst) begin
      q8.delete();
      q4.delete();
   end

   // Scoreboard compare: every cycle with out_valid, plus handshake rule and latency floor.
   always @(posedge clk) begin
      if (!rst) begin
         check("ready8_rule", 32'(ir8), 32'(!ov8 || or8));
         check("ready4_rule", 32'(ir4), 32'(!ov4 || or4));
         if (ov8) begin
            if (q8.size() == 0) begin
               check("dut8_spurious_out", 32'(ov8), 32'd0);
            end else begin
               check("dut8_sum", 32'({c8, s8}), 32'(q8[0].r));
               check("dut8_latency_ge2", 32'((cyc - q8[0].cyc) >= 2), 32'd1);
               if (or8) void'(q8.pop_front());
            end
         end
         if (ov4) begin
            if (q4.size() == 0) begin
               check("dut4_spurious_out", 32'(ov4), 32'd0);
            end else begin
               check("dut4_sum", 32'({c4, s4}), 32'(q4[0].r));
               check("dut4_latency_ge4", 32'((cyc - q4[0].cyc) >= 4), 32'd1);
               if (or4) begin
                  void'(q4.pop_front());
                  n_out4 <= n_out4 + 1;
               end
            end
         end
         if (iv8 && ir8) q8.push_back('{model8(a8, b8, y8, sub8), cyc});
         if (iv4 && ir4) q4.push_back('{model4(a4, b4, y4), cyc});
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog_timeout cycles=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int tries;
      rst = 1'b1;
      iv8 = 1'b0; a8 = '0; b8 = '0; y8 = 1'b0; sub8 = 1'b0; or8 = 1'b1;
      iv4 = 1'b0; a4 = '0; b4 = '0; y4 = 1'b0; sub4 = 1'b0; or4 = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_ov8", 32'(ov8), 32'd0);
      check("rst_s8", 32'(s8), 32'd0);
      check("rst_c8", 32'(c8), 32'd0);
      check("rst_ov4", 32'(ov4), 32'd0);
      check("rst_s4", 32'(s4), 32'd0);
      rst = 1'b0;
      #1 check("rst_ir8", 32'(ir8), 32'd1);

      // Literal pins on the reference model.
      check("model_ff01", 32'(model8(8'hFF, 8'h01, 1'b0, 1'b0)), 32'h100);
      check("model_8080", 32'(model8(8'h80, 8'h80, 1'b1, 1'b0)), 32'h101);
      check("model_sub57", 32'(model8(8'h05, 8'h07, 1'b0, 1'b1)), 32'h0FE);
      check("model4_max", 32'(model4(4'hF, 4'hF, 1'b1)), 32'h1F);

      // Test 1: FF + 01 + 0, two-cycle latency.
      @(negedge clk); iv8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; y8 = 1'b0;
      @(negedge clk); iv8 = 1'b0;
      check("t1_not_yet", 32'(ov8), 32'd0);
      @(negedge clk);
      check("t1_valid", 32'(ov8), 32'd1);
      check("t1_s", 32'(s8), 32'h00);
      check("t1_c", 32'(c8), 32'd1);

      // Test 2: three back-to-back ops emerge on three consecutive cycles.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            check("t2_valid", 32'(ov8), 32'd1);
            check("t2_s", 32'(s8), 32'(t2_s[i-2]));
            check("t2_c", 32'(c8), 32'(t2_c[i-2]));
         end
         if (i < 3) begin
            iv8 = 1'b1; a8 = t2_a[i]; b8 = t2_b[i]; y8 = t2_y[i];
         end else begin
            iv8 = 1'b0;
         end
      end

      // Test 3: fill, stall four cycles with a pending input, then release.
      @(negedge clk); iv8 = 1'b1; a8 = 8'h10; b8 = 8'h20; y8 = 1'b0;
      @(negedge clk); a8 = 8'h33; b8 = 8'h44; y8 = 1'b1;
      @(negedge clk); a8 = 8'hF0; b8 = 8'h0F; y8 = 1'b1; or8 = 1'b0;
      #1;
      check("t3_head_s", 32'(s8), 32'h30);
      check("t3_head_c", 32'(c8), 32'd0);
      check("t3_ir_low", 32'(ir8), 32'd0);
      snap_s = s8; snap_c = c8;
      repeat (4) begin
         @(negedge clk); #1;
         check("t3_stall_ir", 32'(ir8), 32'd0);
         check("t3_stall_ov", 32'(ov8), 32'd1);
         check("t3_stall_s", 32'(s8), 32'(snap_s));
         check("t3_stall_c", 32'(c8), 32'(snap_c));
      end
      or8 = 1'b1;
      @(negedge clk); iv8 = 1'b0;
      repeat (4) @(negedge clk);
      check("t3_drained", 32'(q8.size()), 32'd0);

      // Test 4: asynchronous reset with two ops in flight.
      @(negedge clk); iv8 = 1'b1; a8 = 8'h12; b8 = 8'h34; y8 = 1'b0;
      @(negedge clk); a8 = 8'hFF; b8 = 8'hFF; y8 = 1'b1;
      @(negedge clk); iv8 = 1'b0;
      check("t4_pre_ov", 32'(ov8), 32'd1);
      check("t4_pre_s", 32'(s8), 32'h46);
      #2 rst = 1'b1;
      #1;
      check("t4_rst_ov", 32'(ov8), 32'd0);
      check("t4_rst_s", 32'(s8), 32'd0);
      check("t4_rst_c", 32'(c8), 32'd0);
      @(negedge clk); rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         check("t4_quiet", 32'(ov8), 32'd0);
      end

`ifdef ADDSUB_EN
      // Test 5: subtract mode.
      @(negedge clk); iv8 = 1'b1; sub8 = 1'b1; a8 = 8'h05; b8 = 8'h07; y8 = 1'b0;
      @(negedge clk); a8 = 8'h07; b8 = 8'h05;
      @(negedge clk); iv8 = 1'b0; sub8 = 1'b0;
      check("t5_s0", 32'(s8), 32'hFE);
      check("t5_c0", 32'(c8), 32'd0);
      @(negedge clk);
      check("t5_s1", 32'(s8), 32'h02);
      check("t5_c1", 32'(c8), 32'd1);
`endif

      // Test 6a: 4-bit/4-stage latency with an empty pipe.
      @(negedge clk); iv4 = 1'b1; a4 = 4'hF; b4 = 4'h1; y4 = 1'b1;
      @(negedge clk); iv4 = 1'b0;
      check("t6_lat_n1", 32'(ov4), 32'd0);
      repeat (2) begin
         @(negedge clk);
         check("t6_lat_n", 32'(ov4), 32'd0);
      end
      @(negedge clk);
      check("t6_lat_valid", 32'(ov4), 32'd1);
      check("t6_lat_s", 32'(s4), 32'h1);
      check("t6_lat_c", 32'(c4), 32'd1);

      // Test 6b: exhaustive a,b,y with random out_ready.
      for (int v = 0; v < 512; v++) begin
         @(negedge clk);
         iv4 = 1'b1; a4 = v[3:0]; b4 = v[7:4]; y4 = v[8];
         tries = 0;
         forever begin
            or4 = ($urandom_range(0, 3) != 0);
            #1;
            if (ir4) break;
            @(negedge clk);
            tries++;
            if (tries > 100) begin
               check("t6_accept_timeout", 32'(tries), 32'd0);
               break;
            end
         end
      end
      @(negedge clk); iv4 = 1'b0; or4 = 1'b1;
      repeat (10) @(negedge clk);
      check("t6_drained", 32'(q4.size()), 32'd0);
      check("t6_count", 32'(n_out4), 32'd513);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
